// File: rtl/apu_frame_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apu_frame_sequencer_if
// Brief    : CPU-side register strobes into the frame sequencer and the
//            quarter/half clock enables, IRQ and mode it produces.
// Revision : 1.0 - initial release
// ============================================================================
interface apu_frame_sequencer_if;
    logic       cpu_clk_en;
    logic       frame_wr;
    logic [7:0] frame_wr_data;
    logic       status_rd;
    logic       quarter_clk_en;
    logic       half_clk_en;
    logic       frame_irq;
    logic       mode;

    modport master (
        output cpu_clk_en,
        output frame_wr,
        output frame_wr_data,
        output status_rd,
        input  quarter_clk_en,
        input  half_clk_en,
        input  frame_irq,
        input  mode
    );

    modport slave (
        input  cpu_clk_en,
        input  frame_wr,
        input  frame_wr_data,
        input  status_rd,
        output quarter_clk_en,
        output half_clk_en,
        output frame_irq,
        output mode
    );
endinterface
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apu_frame_sequencer
// Brief    : APU frame counter: 4/5-step sequencer producing quarter- and
//            half-frame clock enables plus the frame IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module apu_frame_sequencer #(
    parameter int CNT_WIDTH = 16,
    parameter int Q1        = 7456,
    parameter int Q2        = 14912,
    parameter int Q3        = 22370,
    parameter int Q4        = 29828,
    parameter int Q5        = 37280
) (
    input  wire logic            clk,
    input  wire logic            rst,
    apu_frame_sequencer_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] c_q1      = CNT_WIDTH'(Q1);
    localparam logic [CNT_WIDTH-1:0] c_q2      = CNT_WIDTH'(Q2);
    localparam logic [CNT_WIDTH-1:0] c_q3      = CNT_WIDTH'(Q3);
    localparam logic [CNT_WIDTH-1:0] c_q4      = CNT_WIDTH'(Q4);
    localparam logic [CNT_WIDTH-1:0] c_q4p1    = CNT_WIDTH'(Q4 + 1);
    localparam logic [CNT_WIDTH-1:0] c_q5      = CNT_WIDTH'(Q5);
    localparam logic [CNT_WIDTH-1:0] c_q5p1    = CNT_WIDTH'(Q5 + 1);
    localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);
    localparam logic [2:0]           c_dly_even = 3'd3;
    localparam logic [2:0]           c_dly_odd  = 3'd4;

    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_mode;
    logic                 r_inhibit;
    logic                 r_irq;
    logic                 r_quarter;
    logic                 r_half;
    logic                 r_parity;
    logic                 r_pending;
    logic [2:0]           r_delay;

    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_last;
    logic                 w_tick;
    logic                 w_step_q;
    logic                 w_step_qh;
    logic                 w_done;
    logic                 w_quarter_nxt;
    logic                 w_half_nxt;
    logic                 w_irq_set;
    logic                 w_irq_clr;
    logic                 w_irq_nxt;
    logic                 w_pending_nxt;
    logic [2:0]           w_delay_nxt;
    logic                 w_unused_data;

    assign w_unused_data = ^bus.frame_wr_data[5:0];

    always_comb begin
        w_tick    = bus.cpu_clk_en;
        w_last    = r_mode ? c_q5p1 : c_q4p1;

        w_step_q  = (r_count == c_q1) || (r_count == c_q3);
        w_step_qh = (r_count == c_q2)
                 || (!r_mode && (r_count == c_q4))
                 || ( r_mode && (r_count == c_q5));

        // A new write restarts the delay, so it also cancels a completion
        // that would otherwise land on this tick.
        w_done    = w_tick && r_pending && (r_delay == 3'd1) && !bus.frame_wr;

        w_quarter_nxt = (w_tick && (w_step_q || w_step_qh)) || (w_done && r_mode);
        w_half_nxt    = (w_tick && w_step_qh) || (w_done && r_mode);

        w_irq_set = w_tick && !r_mode && !r_inhibit
                 && ((r_count == c_q4) || (r_count == c_q4p1));
        w_irq_clr = bus.status_rd || (bus.frame_wr && bus.frame_wr_data[6]);
        w_irq_nxt = r_irq;
        if (w_irq_set) begin
            w_irq_nxt = 1'b1;
        end else if (w_irq_clr) begin
            w_irq_nxt = 1'b0;
        end

        // >= rather than == so a switch to 4-step beyond its last step wraps.
        w_count_nxt = r_count;
        if (w_done) begin
            w_count_nxt = '0;
        end else if (w_tick) begin
            w_count_nxt = (r_count >= w_last) ? '0 : r_count + c_one;
        end

        w_pending_nxt = r_pending;
        w_delay_nxt   = r_delay;
        if (bus.frame_wr) begin
            w_pending_nxt = 1'b1;
            w_delay_nxt   = r_parity ? c_dly_odd : c_dly_even;
        end else if (w_tick && r_pending) begin
            w_delay_nxt = r_delay - 3'd1;
            if (r_delay == 3'd1) begin
                w_pending_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_mode    <= 1'b0;
            r_inhibit <= 1'b0;
            r_irq     <= 1'b0;
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
            r_parity  <= 1'b0;
            r_pending <= 1'b0;
            r_delay   <= 3'd0;
        end else begin
            r_count   <= w_count_nxt;
            r_irq     <= w_irq_nxt;
            r_quarter <= w_quarter_nxt;
            r_half    <= w_half_nxt;
            r_pending <= w_pending_nxt;
            r_delay   <= w_delay_nxt;
            if (w_tick) begin
                r_parity <= ~r_parity;
            end
            if (bus.frame_wr) begin
                r_mode    <= bus.frame_wr_data[7];
                r_inhibit <= bus.frame_wr_data[6];
            end
        end
    end

    assign bus.quarter_clk_en = r_quarter;
    assign bus.half_clk_en    = r_half;
    assign bus.frame_irq      = r_irq;
    assign bus.mode           = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apu_frame_sequencer
// Brief    : Directed bench: a scaled-timing instance for sequencing corner
//            cases plus a default NTSC instance for the real step counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_frame_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic rst_d;

    always #5 clk = ~clk;

    apu_frame_sequencer_if bus();
    apu_frame_sequencer_if dbus();

    apu_frame_sequencer #(
        .CNT_WIDTH (8),
        .Q1        (10),
        .Q2        (20),
        .Q3        (30),
        .Q4        (40),
        .Q5        (50)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    apu_frame_sequencer u_dut_ntsc (
        .clk (clk),
        .rst (rst_d),
        .bus (dbus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;
    int rt      = 0;
    int qlog[$];
    int hlog[$];
    int ex[$];
    bit d_done  = 1'b0;

    task automatic chk_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int got[$], input int e[$]);
        chk_val({tag, "_n"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            chk_val(tag, (i < got.size()) ? got[i] : -99, e[i]);
        end
    endtask

    // One clk; pulses seen after a tick edge are logged against that tick.
    task automatic cyc(input bit en);
        bus.cpu_clk_en = en;
        @(posedge clk);
        #1;
        bus.cpu_clk_en = 1'b0;
        bus.frame_wr   = 1'b0;
        bus.status_rd  = 1'b0;
        if (en) begin
            if (bus.quarter_clk_en) qlog.push_back(rt);
            if (bus.half_clk_en)    hlog.push_back(rt);
            rt++;
        end else if (bus.quarter_clk_en || bus.half_clk_en) begin
            qlog.push_back(-1);
            hlog.push_back(-1);
        end
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            repeat (gap) cyc(1'b0);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.frame_wr      = 1'b1;
        bus.frame_wr_data = d;
        cyc(1'b0);
    endtask

    task automatic clr_log;
        qlog.delete();
        hlog.delete();
        rt = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
        clr_log();
    endtask

    // Default-parameter instance: ticks every clk from reset release.
    initial begin
        int dq[$];
        int dh[$];
        int d_irq;
        d_irq              = -1;
        rst_d              = 1'b1;
        dbus.cpu_clk_en    = 1'b0;
        dbus.frame_wr      = 1'b0;
        dbus.frame_wr_data = 8'h00;
        dbus.status_rd     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_d           = 1'b0;
        dbus.cpu_clk_en = 1'b1;
        for (int i = 0; i < 37290; i++) begin
            @(posedge clk);
            #1;
            if (dbus.quarter_clk_en) dq.push_back(i);
            if (dbus.half_clk_en)    dh.push_back(i);
            if (dbus.frame_irq && d_irq < 0) d_irq = i;
        end
        ex = '{7456, 14912, 22370, 29828, 37286};
        chk_log("ntsc_q", dq, ex);
        ex = '{14912, 29828};
        chk_log("ntsc_h", dh, ex);
        chk_val("ntsc_irq_tick", d_irq, 29828);
        d_done = 1'b1;
    end

    initial begin
        int guard;
        rst               = 1'b1;
        bus.cpu_clk_en    = 1'b1;
        bus.frame_wr      = 1'b0;
        bus.frame_wr_data = 8'h00;
        bus.status_rd     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_quarter", bus.quarter_clk_en, 0);
        chk_val("rst_half",    bus.half_clk_en,    0);
        chk_val("rst_irq",     bus.frame_irq,      0);
        chk_val("rst_mode",    bus.mode,           0);
        bus.cpu_clk_en = 1'b0;
        rst = 1'b0;
        clr_log();

        // 4-step, one tick every 3 clks
        ticks(40, 2);
        chk_val("m0_irq_pre", bus.frame_irq, 0);
        ticks(1, 2);
        chk_val("m0_irq_set", bus.frame_irq, 1);
        ticks(12, 2);
        ex = '{10, 20, 30, 40, 52};
        chk_log("m0_q", qlog, ex);
        ex = '{20, 40};
        chk_log("m0_h", hlog, ex);
        chk_val("m0_irq_hold", bus.frame_irq, 1);

        bus.status_rd = 1'b1;
        cyc(1'b0);
        chk_val("rd_clear", bus.frame_irq, 0);
        ticks(29, 0);
        bus.status_rd = 1'b1;
        ticks(1, 0);
        chk_val("rd_set_wins", bus.frame_irq, 1);
        ticks(1, 0);

        // no ticks: nothing moves
        clr_log();
        repeat (1000) cyc(1'b0);
        chk_val("idle_pulses", qlog.size(), 0);
        chk_val("idle_irq", bus.frame_irq, 1);
        clr_log();
        ticks(11, 0);
        ex = '{10};
        chk_log("idle_resume_q", qlog, ex);

        wr(8'h40);
        chk_val("inh_clear", bus.frame_irq, 0);
        ticks(60, 0);
        chk_val("inh_hold", bus.frame_irq, 0);

        // write at odd parity: 4-tick delay, silent reset in 4-step
        do_reset();
        ticks(1, 0);
        wr(8'h00);
        clr_log();
        ticks(15, 0);
        ex = '{14};
        chk_log("odd_wr_q", qlog, ex);
        chk_val("odd_wr_h_n", hlog.size(), 0);

        wr(8'h00);
        clr_log();
        ticks(2, 0);
        wr(8'h00);
        ticks(14, 0);
        ex = '{15};
        chk_log("restart_q", qlog, ex);

        bus.frame_wr      = 1'b1;
        bus.frame_wr_data = 8'h00;
        clr_log();
        ticks(15, 0);
        ex = '{14};
        chk_log("coinc_q", qlog, ex);

        // 5-step
        do_reset();
        wr(8'h80);
        chk_val("m1_mode", bus.mode, 1);
        clr_log();
        ticks(66, 0);
        ex = '{2, 13, 23, 33, 53, 65};
        chk_log("m1_q", qlog, ex);
        ex = '{2, 23, 53};
        chk_log("m1_h", hlog, ex);
        chk_val("m1_irq", bus.frame_irq, 0);

        // drop to 4-step at count 45; rewrites keep the pending reset away
        ticks(34, 0);
        clr_log();
        for (int i = 0; i < 7; i++) begin
            wr(8'h00);
            ticks(2, 0);
        end
        ticks(1, 0);
        ex = '{11};
        chk_log("wrap_q", qlog, ex);
        chk_val("wrap_h_n", hlog.size(), 0);
        chk_val("wrap_mode", bus.mode, 0);

        // reset mid-frame with IRQ set and a write pending
        do_reset();
        ticks(42, 0);
        chk_val("mid_irq", bus.frame_irq, 1);
        ticks(8, 0);
        wr(8'h80);
        ticks(2, 0);
        bus.cpu_clk_en = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_clk_en = 1'b0;
        chk_val("mid_rst_quarter", bus.quarter_clk_en, 0);
        chk_val("mid_rst_half",    bus.half_clk_en,    0);
        chk_val("mid_rst_irq",     bus.frame_irq,      0);
        chk_val("mid_rst_mode",    bus.mode,           0);
        rst = 1'b0;
        clr_log();
        ticks(11, 0);
        ex = '{10};
        chk_log("mid_rst_q", qlog, ex);

        guard = 0;
        while (!d_done && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        chk_val("ntsc_done", int'(d_done), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
